// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: latches edge-detected alarm requests and grants a shared
// buzzer to one channel at a time in round-robin order. Each granted tone
// lasts a programmable number of cycles and is followed by a programmable
// silent gap. Mute aborts a running tone and blocks new grants.
module buzzer_arbiter #(
    parameter int NREQ  = 3,
    parameter int DUR_W = 5,
    parameter int GAP_W = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         clear,
    input  logic [DUR_W-1:0]        dur_cfg,
    input  logic [GAP_W-1:0]        gap_cfg,
    input  logic                    mute,
    output logic [NREQ-1:0]         buzz,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [NREQ-1:0]         pending,
    output logic                    busy,
    output logic                    done
);

    localparam int ID_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [NREQ-1:0]   req_d_r;
    logic [NREQ-1:0]   pending_r, pending_s;
    logic [NREQ-1:0]   buzz_r, buzz_s;
    logic [ID_W-1:0]   grant_id_r, grant_id_s;
    logic [ID_W-1:0]   rr_ptr_r, rr_ptr_s;
    logic [DUR_W-1:0]  tone_cnt_r, tone_cnt_s;
    logic [GAP_W-1:0]  gap_cnt_r, gap_cnt_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;

    logic [NREQ-1:0]   rise_s;
    logic [NREQ-1:0]   grant_clr_s;
    logic [NREQ-1:0]   onehot_s;
    logic [ID_W-1:0]   pick_s;
    logic [ID_W-1:0]   rr_next_s;
    logic              found_s;

    // Rising-edge detect of the level requests against the previous sample
    assign rise_s = req & ~req_d_r;

    // Round-robin search: first pending channel at or after the pointer
    always_comb begin : pick_blk
        int              sum_v;
        logic [ID_W-1:0] idx_v;
        sum_v   = 0;
        idx_v   = '0;
        found_s = 1'b0;
        pick_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum_v = int'(rr_ptr_r) + k;
            sum_v = (sum_v >= NREQ) ? (sum_v - NREQ) : sum_v;
            idx_v = ID_W'(sum_v);
            if (!found_s && pending_r[idx_v]) begin
                found_s = 1'b1;
                pick_s  = idx_v;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Decode the picked channel and the pointer that follows it
    always_comb begin : ptr_blk
        int nxt_v;
        nxt_v     = int'(pick_s) + 1;
        rr_next_s = (nxt_v >= NREQ) ? '0 : ID_W'(nxt_v);
        onehot_s  = {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
    end

    // Next-state and output decode for the IDLE/TONE/GAP sequencer
    always_comb begin
        state_s     = state_r;
        buzz_s      = buzz_r;
        grant_id_s  = grant_id_r;
        rr_ptr_s    = rr_ptr_r;
        tone_cnt_s  = tone_cnt_r;
        gap_cnt_s   = gap_cnt_r;
        done_s      = 1'b0;
        grant_clr_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (!mute && found_s) begin
                    state_s     = ST_TONE;
                    buzz_s      = onehot_s;
                    grant_id_s  = pick_s;
                    rr_ptr_s    = rr_next_s;
                    grant_clr_s = onehot_s;
                    tone_cnt_s  = (dur_cfg == '0) ? DUR_W'(1) : dur_cfg;
                end else begin
                    buzz_s = '0;
                end
            end
            ST_TONE: begin
                if (mute) begin
                    // Abort: silence immediately, no completion pulse
                    state_s   = ST_GAP;
                    buzz_s    = '0;
                    gap_cnt_s = gap_cfg;
                end else if (tone_cnt_r <= DUR_W'(1)) begin
                    buzz_s    = '0;
                    done_s    = 1'b1;
                    gap_cnt_s = gap_cfg;
                    state_s   = (gap_cfg == '0) ? ST_IDLE : ST_GAP;
                end else begin
                    tone_cnt_s = tone_cnt_r - DUR_W'(1);
                end
            end
            ST_GAP: begin
                buzz_s = '0;
                if (gap_cnt_r <= GAP_W'(1)) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r - GAP_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                buzz_s  = '0;
            end
        endcase
        // A new edge on the granted channel in the grant cycle re-arms it
        pending_s = (pending_r & ~clear & ~grant_clr_s) | rise_s;
        busy_s    = (state_s != ST_IDLE);
    end

    // State and output registers; en low freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            req_d_r    <= '0;
            pending_r  <= '0;
            buzz_r     <= '0;
            grant_id_r <= '0;
            rr_ptr_r   <= '0;
            tone_cnt_r <= '0;
            gap_cnt_r  <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (en) begin
            state_r    <= state_s;
            req_d_r    <= req;
            pending_r  <= pending_s;
            buzz_r     <= buzz_s;
            grant_id_r <= grant_id_s;
            rr_ptr_r   <= rr_ptr_s;
            tone_cnt_r <= tone_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end else begin
            state_r <= state_r;
        end
    end

    assign buzz     = buzz_r;
    assign grant_id = grant_id_r;
    assign pending  = pending_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed testbench for buzzer_arbiter (NREQ=3, DUR_W=5, GAP_W=3).
module tb_buzzer_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] req;
    logic [2:0] clear;
    logic [4:0] dur_cfg;
    logic [2:0] gap_cfg;
    logic       mute;
    logic [2:0] buzz;
    logic [1:0] grant_id;
    logic [2:0] pending;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    buzzer_arbiter #(.NREQ(3), .DUR_W(5), .GAP_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .clear(clear),
        .dur_cfg(dur_cfg), .gap_cfg(gap_cfg), .mute(mute),
        .buzz(buzz), .grant_id(grant_id), .pending(pending),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        en      = 1'b1;
        req     = 3'b000;
        clear   = 3'b000;
        mute    = 1'b0;
        dur_cfg = 5'd4;
        gap_cfg = 3'd2;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (buzz !== 3'b000) begin errors++; $display("FAIL reset_buzz: got %b expected 000", buzz); end
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL reset_pending: got %b expected 000", pending); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 3'b010;
        step();                     // E0
        step();                     // E1: ch1 tone starts
        checks++; if (buzz !== 3'b010) begin errors++; $display("FAIL arst_pre_buzz: got %b expected 010", buzz); end
        #2;
        rst_n = 1'b0;
        #1;                         // mid-cycle, no clock edge yet
        checks++; if (buzz !== 3'b000) begin errors++; $display("FAIL arst_buzz: got %b expected 000", buzz); end
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL arst_pending: got %b expected 000", pending); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL arst_grant_id: got %0d expected 0", grant_id); end
    endtask

    task automatic test_single_tone();
        logic [2:0] eb;
        logic       ed;
        logic       ey;
        do_reset();
        req = 3'b010;
        step();                     // E0
        checks++; if (pending !== 3'b010) begin errors++; $display("FAIL single_pending_e0: got %b expected 010", pending); end
        checks++; if (buzz !== 3'b000) begin errors++; $display("FAIL single_buzz_e0: got %b expected 000", buzz); end
        for (int c = 1; c <= 8; c++) begin
            step();
            eb = (c <= 4) ? 3'b010 : 3'b000;
            ed = (c == 5);
            ey = (c <= 6);
            checks++; if (buzz !== eb) begin errors++; $display("FAIL single_buzz_e%0d: got %b expected %b", c, buzz, eb); end
            checks++; if (done !== ed) begin errors++; $display("FAIL single_done_e%0d: got %b expected %b", c, done, ed); end
            checks++; if (busy !== ey) begin errors++; $display("FAIL single_busy_e%0d: got %b expected %b", c, busy, ey); end
            if (c == 1) begin
                checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_grant_id: got %0d expected 1", grant_id); end
                checks++; if (pending !== 3'b000) begin errors++; $display("FAIL single_pending_e1: got %b expected 000", pending); end
            end
        end
        req = 3'b000;
    endtask

    task automatic test_round_robin();
        int         ch;
        int         ph;
        logic [2:0] eb;
        logic [2:0] ep;
        do_reset();
        req = 3'b111;
        step();                     // E0
        checks++; if (pending !== 3'b111) begin errors++; $display("FAIL rr_pending_e0: got %b expected 111", pending); end
        for (int c = 1; c <= 21; c++) begin
            step();
            ch = (c - 1) / 7;
            ph = (c - 1) % 7;
            eb = (ph < 4) ? (3'b001 << ch) : 3'b000;
            checks++; if (buzz !== eb) begin errors++; $display("FAIL rr_buzz_e%0d: got %b expected %b", c, buzz, eb); end
            if (ph == 0) begin
                ep = 3'b110 << ch;
                checks++; if (grant_id !== 2'(ch)) begin errors++; $display("FAIL rr_grant_e%0d: got %0d expected %0d", c, grant_id, ch); end
                checks++; if (pending !== ep) begin errors++; $display("FAIL rr_pending_e%0d: got %b expected %b", c, pending, ep); end
            end
            if (ph == 4) begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL rr_done_e%0d: got %b expected 1", c, done); end
            end
        end
        req = 3'b000;
    endtask

    task automatic test_fairness();
        int         ord [4] = '{0, 1, 2, 0};
        logic [2:0] eb;
        do_reset();
        req = 3'b111;
        step();                     // E0
        for (int c = 1; c <= 22; c++) begin
            step();
            if ((c - 1) % 7 == 0) begin
                eb = 3'b001 << ord[(c - 1) / 7];
                checks++; if (buzz !== eb) begin errors++; $display("FAIL fair_buzz_e%0d: got %b expected %b", c, buzz, eb); end
            end
            if (c == 3) begin
                checks++; if (pending !== 3'b111) begin errors++; $display("FAIL fair_pending_e3: got %b expected 111", pending); end
            end
            if (c == 1) req = 3'b110;
            if (c == 2) req = 3'b111;   // fresh edge on ch0 during its own tone
        end
        req = 3'b000;
    endtask

    task automatic test_mute_clear();
        do_reset();
        req = 3'b100;
        step();                     // E0
        step();                     // E1: ch2 tone
        checks++; if (buzz !== 3'b100) begin errors++; $display("FAIL mute_pre_buzz: got %b expected 100", buzz); end
        req = 3'b111;
        step();                     // E2: 2nd tone cycle, ch0/ch1 pend
        mute = 1'b1;
        for (int c = 3; c <= 6; c++) begin
            step();
            checks++; if (buzz !== 3'b000) begin errors++; $display("FAIL mute_buzz_e%0d: got %b expected 000", c, buzz); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL mute_done_e%0d: got %b expected 0", c, done); end
            checks++; if (pending !== 3'b011) begin errors++; $display("FAIL mute_pending_e%0d: got %b expected 011", c, pending); end
        end
        mute = 1'b0;
        step();                     // E7: grants resume on ch0
        checks++; if (buzz !== 3'b001) begin errors++; $display("FAIL mute_resume_buzz: got %b expected 001", buzz); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL mute_resume_grant: got %0d expected 0", grant_id); end
        checks++; if (pending !== 3'b010) begin errors++; $display("FAIL mute_resume_pending: got %b expected 010", pending); end
        req = 3'b101;
        step();                     // E8
        req   = 3'b111;
        clear = 3'b010;
        step();                     // E9: set and clear together
        checks++; if (pending !== 3'b010) begin errors++; $display("FAIL clear_vs_set: got %b expected 010", pending); end
        step();                     // E10: plain clear
        clear = 3'b000;
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL clear_only: got %b expected 000", pending); end
        req = 3'b000;
    endtask

    task automatic test_min_dur();
        logic [2:0] eb [5] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b000};
        logic       ed [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        dur_cfg = 5'd0;
        gap_cfg = 3'd0;
        req = 3'b011;
        step();                     // E0
        for (int c = 1; c <= 5; c++) begin
            step();
            checks++; if (buzz !== eb[c-1]) begin errors++; $display("FAIL mindur_buzz_e%0d: got %b expected %b", c, buzz, eb[c-1]); end
            checks++; if (done !== ed[c-1]) begin errors++; $display("FAIL mindur_done_e%0d: got %b expected %b", c, done, ed[c-1]); end
        end
        req = 3'b000;
    endtask

    task automatic test_enable_hold();
        logic [2:0] eb;
        do_reset();
        gap_cfg = 3'd0;
        req = 3'b001;
        step();                     // E0
        for (int c = 1; c <= 9; c++) begin
            step();
            eb = (c <= 7) ? 3'b001 : 3'b000;
            checks++; if (buzz !== eb) begin errors++; $display("FAIL en_buzz_e%0d: got %b expected %b", c, buzz, eb); end
            if (c == 8) begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL en_done_e8: got %b expected 1", done); end
                checks++; if (pending !== 3'b000) begin errors++; $display("FAIL en_lost_pulse: got %b expected 000", pending); end
            end
            if (c == 2) en = 1'b0;          // E3..E5 frozen
            if (c == 3) req = 3'b011;       // pulse fully inside en=0
            if (c == 4) req = 3'b001;
            if (c == 5) en = 1'b1;
        end
        req = 3'b000;
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_single_tone();
        test_round_robin();
        test_fairness();
        test_mute_clear();
        test_min_dur();
        test_enable_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
